// File: rtl/fft_pkg.sv
// Shared types, constants and complex-word helpers for the FFT stage.
package fft_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int DEF_W    = 32;
  localparam int DEF_FRAC = 30;

  // Widest intermediate the helpers handle; component widths must stay well below.
  localparam int MAXW = 128;

  typedef struct packed {
    logic                   clip;
    logic signed [MAXW-1:0] val;
  } sat_t;

  // Real part (upper w bits of a 2w-bit word), sign-extended.
  function automatic logic signed [MAXW-1:0] cre(input logic [2*MAXW-1:0] c, input int unsigned w);
    logic signed [MAXW-1:0] r;
    for (int unsigned i = 0; i < MAXW; i++) r[i] = (i < w) ? c[w+i] : c[2*w-1];
    return r;
  endfunction

  // Imaginary part (lower w bits), sign-extended.
  function automatic logic signed [MAXW-1:0] cim(input logic [2*MAXW-1:0] c, input int unsigned w);
    logic signed [MAXW-1:0] r;
    for (int unsigned i = 0; i < MAXW; i++) r[i] = (i < w) ? c[i] : c[w-1];
    return r;
  endfunction

  // Pack the low w bits of re/im into one 2w-bit word, real on top.
  function automatic logic [2*MAXW-1:0] cpack(input logic [MAXW-1:0] re, input logic [MAXW-1:0] im,
                                               input int unsigned w);
    logic [2*MAXW-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < MAXW; i++) begin
      if (i < w) begin
        r[i]   = im[i];
        r[w+i] = re[i];
      end
    end
    return r;
  endfunction

  // Clamp to the signed w-bit range and report whether clipping happened.
  function automatic sat_t sat(input logic signed [MAXW-1:0] v, input int unsigned w);
    sat_t                   r;
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    hi        = '0;
    hi[w-1]   = 1'b1;
    hi        = hi - 1;
    lo        = -hi - 1;
    r.clip    = (v > hi) || (v < lo);
    r.val     = (v > hi) ? hi : ((v < lo) ? lo : v);
    return r;
  endfunction

endpackage

// File: rtl/fft_bfly.sv
// Registered radix-2 complex butterfly with twiddle rounding, optional halving and saturation.
module fft_bfly
  import fft_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int FRAC  = DEF_FRAC,
  parameter int SCALE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [2*W-1:0] xa,
  input  logic [2*W-1:0] xb,
  input  logic [2*W-1:0] tw,
  output logic [2*W-1:0] ya,
  output logic [2*W-1:0] yb,
  output logic         clip
);

  // Wide enough for the full complex product plus rounding and sum growth.
  localparam int PW = 2*W + 3;

  if (PW > MAXW) begin : g_bad_w
    $error("fft_bfly: W too large for helper width");
  end

  logic signed [W-1:0]  ar, ai, br, bi, wr, wi;
  logic signed [PW-1:0] pr, pi;
  logic signed [PW-1:0] sum [4];
  sat_t                 st  [4];
  logic [2*W-1:0]       ya_n, yb_n;
  logic                 clip_n;

  // Unpack, multiply, round, add/subtract, scale and saturate.
  always_comb begin
    ar = W'(cre((2*MAXW)'(xa), W));
    ai = W'(cim((2*MAXW)'(xa), W));
    br = W'(cre((2*MAXW)'(xb), W));
    bi = W'(cim((2*MAXW)'(xb), W));
    wr = W'(cre((2*MAXW)'(tw), W));
    wi = W'(cim((2*MAXW)'(tw), W));
    pr = PW'(wr) * PW'(br) - PW'(wi) * PW'(bi);
    pi = PW'(wr) * PW'(bi) + PW'(wi) * PW'(br);
    pr = (pr + (PW'(1) <<< (FRAC - 1))) >>> FRAC;
    pi = (pi + (PW'(1) <<< (FRAC - 1))) >>> FRAC;
    sum[0] = PW'(ar) + pr;
    sum[1] = PW'(ai) + pi;
    sum[2] = PW'(ar) - pr;
    sum[3] = PW'(ai) - pi;
    clip_n = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (SCALE != 0) sum[i] = sum[i] >>> 1;
      st[i]  = sat(MAXW'(sum[i]), W);
      clip_n = clip_n | st[i].clip;
    end
    ya_n = (2*W)'(cpack(st[0].val, st[1].val, W));
    yb_n = (2*W)'(cpack(st[2].val, st[3].val, W));
  end

  // Result register, loaded only when a butterfly is issued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ya   <= '0;
      yb   <= '0;
      clip <= 1'b0;
    end else if (en) begin
      ya   <= ya_n;
      yb   <= yb_n;
      clip <= clip_n;
    end
  end

endmodule

// File: rtl/fft_stage_seq.sv
// One radix-2 FFT stage over a buffered frame, one butterfly per cycle.
module fft_stage_seq
  import fft_pkg::*;
#(
  parameter int N     = 32,
  parameter int W     = DEF_W,
  parameter int SPAN  = 16,
  parameter int FRAC  = DEF_FRAC,
  parameter int SCALE = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [N*2*W-1:0]     in_data,
  input  logic [(N/2)*2*W-1:0] tw_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [N*2*W-1:0]     out_data,
  output logic                 ovf,
  output logic                 busy
);

  localparam int H  = N / 2;
  localparam int CW = $clog2(H + 2) + 1;
  localparam int IW = $clog2(N);
  localparam int JW = $clog2(H);
  localparam int LS = $clog2(SPAN);

  if ((N & (N - 1)) != 0 || N < 4 || N > 64) begin : g_bad_n
    $error("fft_stage_seq: N must be a power of 2 in 4..64");
  end
  if ((SPAN & (SPAN - 1)) != 0 || SPAN < 1 || SPAN > H) begin : g_bad_span
    $error("fft_stage_seq: SPAN must be a power of 2 in 1..N/2");
  end

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  fb [N];
  logic [2*W-1:0]  tb [H];
  logic [2*W-1:0]  ob [N];
  logic            ovf_q;
  logic            accept, issue;
  logic [JW-1:0]   j;
  logic [IW-1:0]   jx, ia, ib;
  logic            wv;
  logic [IW-1:0]   wa, wb;
  logic [2*W-1:0]  ya, yb;
  logic            clip;

  assign accept    = (state == IDLE) && in_valid;
  assign issue     = (state == RUN) && (cnt < CW'(H));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign ovf       = ovf_q;

  // Pair indices: a keeps the low LS bits of j and inserts a zero at bit LS; b sets that bit.
  always_comb begin
    j  = cnt[JW-1:0];
    jx = IW'(j);
    ia = ((jx >> LS) << (LS + 1)) | (jx & IW'(SPAN - 1));
    ib = ia | IW'(SPAN);
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  // Next state: RUN covers N/2 issues plus two drain cycles (result reg, output write).
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = RUN;
      RUN:     if (cnt == CW'(H + 1)) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Butterfly / drain counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)             cnt <= '0;
    else if (accept)        cnt <= '0;
    else if (state == RUN)  cnt <= cnt + 1'b1;
  end

  // Frame and twiddle capture on accept.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int unsigned k = 0; k < N; k++) fb[k] <= in_data[k*2*W +: 2*W];
      for (int unsigned k = 0; k < H; k++) tb[k] <= tw_data[k*2*W +: 2*W];
    end
  end

  fft_bfly #(
    .W     (W),
    .FRAC  (FRAC),
    .SCALE (SCALE)
  ) u_bfly (
    .clk   (clk),
    .reset (reset),
    .en    (issue),
    .xa    (fb[ia]),
    .xb    (fb[ib]),
    .tw    (tb[j]),
    .ya    (ya),
    .yb    (yb),
    .clip  (clip)
  );

  // Write-back tag that travels alongside the butterfly result register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wv <= 1'b0;
      wa <= '0;
      wb <= '0;
    end else begin
      wv <= issue;
      wa <= ia;
      wb <= ib;
    end
  end

  // Output buffer and sticky overflow.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned k = 0; k < N; k++) ob[k] <= '0;
      ovf_q <= 1'b0;
    end else if (accept) begin
      ovf_q <= 1'b0;
    end else if (wv) begin
      ob[wa] <= ya;
      ob[wb] <= yb;
      ovf_q  <= ovf_q | clip;
    end
  end

  // Flatten the output buffer onto the port.
  always_comb begin
    out_data = '0;
    for (int unsigned k = 0; k < N; k++) out_data[k*2*W +: 2*W] = ob[k];
  end

endmodule

// File: tb/tb_fft_stage_seq.sv
// Scoreboard bench for fft_stage_seq: three instances, spec-level reference model.
module tb_fft_stage_seq;

  localparam int NI  = 3;
  localparam int DW  = 32 * 64;
  localparam int TWW = 16 * 64;

  typedef struct {
    logic [DW-1:0] d;
    logic          o;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [NI-1:0]  iv, ordy;
  wire  [NI-1:0]  ir, ov, ovf_o, bsy;
  logic [DW-1:0]  din [NI];
  logic [TWW-1:0] twd [NI];
  wire  [DW-1:0]  dout0, dout2;
  wire  [511:0]   dout1;

  int nn  [NI] = '{32, 8, 32};
  int spn [NI] = '{16, 1, 16};
  int scl [NI] = '{0, 0, 1};

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc [NI] = '{0, 0, 0};
  int hs  [NI] = '{0, 0, 0};
  logic [NI-1:0] ovp = '0;
  exp_t sb [NI][$];

  fft_stage_seq #(.N(32), .W(32), .SPAN(16), .FRAC(30), .SCALE(0)) u0 (
    .clk(clk), .reset(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_data(din[0]),
    .tw_data(twd[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(dout0),
    .ovf(ovf_o[0]), .busy(bsy[0]));

  fft_stage_seq #(.N(8), .W(32), .SPAN(1), .FRAC(30), .SCALE(0)) u1 (
    .clk(clk), .reset(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_data(din[1][511:0]),
    .tw_data(twd[1][255:0]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(dout1),
    .ovf(ovf_o[1]), .busy(bsy[1]));

  fft_stage_seq #(.N(32), .W(32), .SPAN(16), .FRAC(30), .SCALE(1)) u2 (
    .clk(clk), .reset(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .in_data(din[2]),
    .tw_data(twd[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(dout2),
    .ovf(ovf_o[2]), .busy(bsy[2]));

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] get_out(input int u);
    case (u)
      0:       return dout0;
      1:       return DW'(dout1);
      default: return dout2;
    endcase
  endfunction

  // ---------------- reference model ----------------
  function automatic logic signed [127:0] comp(input logic [DW-1:0] v, input int k, input bit re);
    logic signed [31:0]  s;
    logic signed [127:0] r;
    s = re ? v[k*64+32 +: 32] : v[k*64 +: 32];
    r = s;
    return r;
  endfunction

  function automatic logic [32:0] clampc(input logic signed [127:0] v, input int sc);
    logic signed [127:0] s;
    s = (sc != 0) ? (v >>> 1) : v;
    if (s > 128'sd2147483647)  return {1'b1, 32'h7FFF_FFFF};
    if (s < -128'sd2147483648) return {1'b1, 32'h8000_0000};
    return {1'b0, s[31:0]};
  endfunction

  function automatic exp_t model(input logic [DW-1:0] x, input logic [TWW-1:0] t,
                                 input int n, input int span, input int sc);
    exp_t r;
    r.d = '0;
    r.o = 1'b0;
    for (int j = 0; j < n / 2; j++) begin
      int a, b;
      logic signed [127:0] ar, ai, br, bi, wr, wi, pr, pi;
      logic [32:0] c;
      a  = (j / span) * 2 * span + (j % span);
      b  = a + span;
      ar = comp(x, a, 1'b1);  ai = comp(x, a, 1'b0);
      br = comp(x, b, 1'b1);  bi = comp(x, b, 1'b0);
      wr = comp(DW'(t), j, 1'b1);  wi = comp(DW'(t), j, 1'b0);
      pr = wr * br - wi * bi;
      pi = wr * bi + wi * br;
      pr = (pr + 128'sd536870912) >>> 30;
      pi = (pi + 128'sd536870912) >>> 30;
      c = clampc(ar + pr, sc);  r.d[a*64+32 +: 32] = c[31:0];  r.o = r.o | c[32];
      c = clampc(ai + pi, sc);  r.d[a*64    +: 32] = c[31:0];  r.o = r.o | c[32];
      c = clampc(ar - pr, sc);  r.d[b*64+32 +: 32] = c[31:0];  r.o = r.o | c[32];
      c = clampc(ai - pi, sc);  r.d[b*64    +: 32] = c[31:0];  r.o = r.o | c[32];
    end
    return r;
  endfunction

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] pt(input logic [DW-1:0] f, input int k,
                                       input logic [31:0] re, input logic [31:0] im);
    f[k*64+32 +: 32] = re;
    f[k*64 +: 32]    = im;
    return f;
  endfunction

  function automatic logic [TWW-1:0] tw_all(input int n, input logic [31:0] re, input logic [31:0] im);
    logic [TWW-1:0] t;
    t = '0;
    for (int k = 0; k < n; k++) t[k*64 +: 64] = {re, im};
    return t;
  endfunction

  function automatic logic [DW-1:0] rnd_frame(input int n, input bit full);
    logic [DW-1:0] f;
    logic [31:0]   re, im;
    f = '0;
    for (int k = 0; k < n; k++) begin
      re = full ? $urandom : 32'(int'($urandom_range(2000, 0)) - 1000);
      im = full ? $urandom : 32'(int'($urandom_range(2000, 0)) - 1000);
      f[k*64 +: 64] = {re, im};
    end
    return f;
  endfunction

  function automatic logic [TWW-1:0] rnd_tw(input int n);
    logic [TWW-1:0] t;
    logic [31:0]    re, im;
    t = '0;
    for (int k = 0; k < n; k++) begin
      re = 32'(int'($urandom_range(32'h7FFF_FFFF, 0)) - 32'sh4000_0000);
      im = 32'(int'($urandom_range(32'h7FFF_FFFF, 0)) - 32'sh4000_0000);
      t[k*64 +: 64] = {re, im};
    end
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // Offer a frame, wait (bounded) for acceptance, push its expected result.
  task automatic send(input int u, input logic [DW-1:0] x, input logic [TWW-1:0] t);
    int n;
    din[u] = x;
    twd[u] = t;
    iv[u]  = 1'b1;
    n = 0;
    while (!ir[u] && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (!ir[u]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout u%0d got in_ready=0 want 1", u);
      iv[u] = 1'b0;
    end else begin
      @(posedge clk); #1;
      acc[u] = cyc;
      sb[u].push_back(model(x, t, nn[u], spn[u], scl[u]));
      iv[u] = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb[0].size() + sb[1].size() + sb[2].size()) != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if ((sb[0].size() + sb[1].size() + sb[2].size()) != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb[0].size() + sb[1].size() + sb[2].size());
    end
  endtask

  task automatic chk_rst(input int u);
    chk($sformatf("rst_ctl_u%0d", u), 64'({ir[u], ov[u], bsy[u], ovf_o[u]}), 64'(4'b1000));
    chk($sformatf("rst_data_u%0d", u), 64'(get_out(u) != '0), 64'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    for (int u = 0; u < NI; u++) begin
      if (ov[u] && !ovp[u]) begin
        checks++;
        if (cyc - acc[u] != nn[u] / 2 + 2) begin
          errors++;
          $display("FAIL latency_u%0d got %0d want %0d", u, cyc - acc[u], nn[u] / 2 + 2);
        end
      end
      ovp[u] = ov[u];
      if (ov[u] && ordy[u]) begin
        hs[u] = cyc + 1;
        if (sb[u].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame_u%0d got out_valid=1 want no frame", u);
        end else begin
          exp_t e;
          logic [DW-1:0] got;
          int kd;
          e   = sb[u].pop_front();
          got = get_out(u);
          kd  = 0;
          for (int k = 0; k < 32; k++) begin
            if (got[k*64 +: 64] !== e.d[k*64 +: 64]) begin
              kd = k;
              break;
            end
          end
          checks++;
          if (got !== e.d) begin
            errors++;
            $display("FAIL data_u%0d point %0d got %h want %h", u, kd, got[kd*64 +: 64], e.d[kd*64 +: 64]);
          end
          checks++;
          if (ovf_o[u] !== e.o) begin
            errors++;
            $display("FAIL ovf_u%0d got %b want %b", u, ovf_o[u], e.o);
          end
        end
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0]  x, snap;
    logic [TWW-1:0] t;
    logic           so;
    int             n;

    iv   = '0;
    ordy = '1;
    for (int u = 0; u < NI; u++) begin
      din[u] = '0;
      twd[u] = '0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NI; u++) chk_rst(u);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Impulse with unit twiddle.
    send(0, pt('0, 0, 32'd100, 32'd0), tw_all(16, 32'h4000_0000, 32'd0));
    // Twiddle -j.
    send(0, pt(pt('0, 0, 32'd5, 32'd0), 16, 32'd3, 32'd0), tw_all(16, 32'd0, 32'hC000_0000));
    // Saturation, unscaled and scaled.
    x = pt(pt('0, 0, 32'h7FFF_FFFF, 32'd0), 16, 32'h7FFF_FFFF, 32'd0);
    t = tw_all(16, 32'h4000_0000, 32'd0);
    send(0, x, t);
    send(2, x, t);
    drain();

    // Backpressure in DONE with a competing frame offered.
    ordy[0] = 1'b0;
    send(0, rnd_frame(32, 1'b1), rnd_tw(16));
    n = 0;
    while (!ov[0] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_valid", 64'(ov[0]), 64'd1);
    snap = dout0;
    so   = ovf_o[0];
    din[0] = rnd_frame(32, 1'b0);
    twd[0] = rnd_tw(16);
    iv[0]  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", 64'({ov[0], ir[0], ovf_o[0], dout0 == snap}), 64'({1'b1, 1'b0, so, 1'b1}));
    end
    ordy[0] = 1'b1;
    send(0, din[0], twd[0]);
    chk("bp_next_accept", 64'(acc[0]), 64'(hs[0] + 1));
    drain();

    // Reset in the middle of RUN, then the same frame again.
    x = rnd_frame(32, 1'b0);
    t = rnd_tw(16);
    send(0, x, t);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_rst(0);
    sb[0].delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, x, t);

    // Random frames on all instances.
    for (int i = 0; i < 6; i++) send(0, rnd_frame(32, 1'(i % 2)), rnd_tw(16));
    for (int i = 0; i < 2; i++) send(2, rnd_frame(32, 1'(i % 2)), rnd_tw(16));
    for (int i = 0; i < 8; i++) send(1, rnd_frame(8, 1'(i % 2)), rnd_tw(4));
    drain();
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < NI; u++) chk($sformatf("leftover_u%0d", u), 64'(sb[u].size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
